acc_instr_seq: RTL
==================

// Module: acc_instr_seq
// PURPOSE
//  Accelerator-side instruction sequencer, directly downstream of the CPU/accelerator control bridge.
//  - Accepts one acc_instr_t at a time and reads its three source operands from the CPU register file.
//  - Issues the operation to the FPU pivot datapath, waits for the result and writes it back.
//  - Single instruction in flight; no reordering.
// PARAMETERS
//  TIMEOUT_CYCLES  64  max cycles in WAIT before abort; must be >=1
//  CNT_W           32  width of the retired/aborted counters
// PORTS
//  clk_i             in   1          clock
//  rst_i             in   1          asynchronous, active-high reset
//  acc_instr_i       in   acc_instr_t  instruction: op, rs[2:0], rd, wb_en
//  acc_instr_valid_i in   1          instruction valid
//  ready_o           out  1          instruction accepted when valid&ready
//  busy_o            out  1          instruction in flight
//  raddr_o           out  3xreg_addr_t  source register addresses
//  rready_o          out  1          operand read request
//  rdata_i           in   3xdata_t   operand data
//  rvalid_i          in   1          operand data valid
//  waddr_o           out  reg_addr_t  write-back address
//  wdata_o           out  data_t     write-back data
//  wren_o            out  1          write request
//  wready_i          in   1          write accepted
//  fpu_op_o          out  acc_op_t   operation to FPU
//  fpu_opnd_o        out  3xdata_t   operands to FPU
//  fpu_valid_o       out  1          FPU issue valid
//  fpu_ready_i       in   1          FPU accepts issue
//  fpu_result_i      in   data_t     FPU result
//  fpu_result_valid_i in  1          FPU result valid (1-cycle pulse)
//  err_o             out  1          1-cycle pulse on timeout abort
//  retired_o         out  CNT_W      completed-instruction count
//  aborted_o         out  CNT_W      timed-out-instruction count
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0 except ready_o=1; latched instruction, operands, result and counters cleared.
//  FSM: IDLE -> READ -> ISSUE -> WAIT -> WRITE -> IDLE.
//  - IDLE: ready_o=1, busy_o=0. On valid&ready, latch acc_instr_i; go to READ next cycle.
//  - READ: raddr_o=latched rs[2:0], rready_o=1 until rvalid_i. On rvalid_i, capture rdata_i; go to ISSUE.
//  - ISSUE: fpu_valid_o=1, fpu_op_o/fpu_opnd_o held stable until fpu_ready_i. On handshake, clear timer; go to WAIT.
//  - WAIT: timer increments each cycle.
//    - fpu_result_valid_i: capture fpu_result_i. Go to WRITE if wb_en=1; else to IDLE and retire.
//    - timer reaches TIMEOUT_CYCLES-1 without result: err_o pulse, aborted_o+1, return to IDLE; no write.
//    - Result and timeout expiry in the same cycle: the result wins.
//  - WRITE: wren_o=1, waddr_o=rd, wdata_o=result, all held until wready_i. On wready_i, retired_o+1; go to IDLE.
//  Outputs: busy_o=(state!=IDLE). ready_o is 1 only in IDLE; back-to-back instructions therefore cost at least 1 IDLE cycle.
//  Latency: minimum 5 cycles accept-to-write (0-wait handshakes, result 1 cycle after issue).
//  Sampling: rvalid_i/wready_i/fpu_result_valid_i outside their state are ignored. A late result arriving in IDLE after an abort is dropped.
//  Counters wrap at 2^CNT_W-1 -> 0 silently.
//  All outputs are registered or decoded from state only; no input-to-output combinational path.
//  Reset mid-operation: immediate return to IDLE; in-flight instruction discarded; no write.
// STRUCTURE
//  acc_pkg holds:
//  - acc_instr_t, acc_op_t, data_t, reg_addr_t
//  - seq_state_e (IDLE, READ, ISSUE, WAIT, WRITE)
//  Sub-module acc_seq_timer: clearable saturating counter with an expiry compare, reused for WAIT timeout.
//  All other logic stays in one FSM plus datapath registers.
// TESTING
//  1. rs={1,2,3}, rd=4, wb_en=1, all ready/valid tied to 1, FPU result 0x3F800000 1 cycle after issue
//     -> wren_o with waddr=4, wdata=0x3F800000 at cycle 5; retired_o=1.
//  2. rvalid_i held 0 for 7 cycles -> rready_o/raddr_o stable 7 cycles; no fpu_valid_o.
//  3. wready_i held 0 for 4 cycles -> wren_o/waddr_o/wdata_o stable; busy_o=1; ready_o=0.
//  4. TIMEOUT_CYCLES=8, no result -> err_o pulse 8 cycles after issue; aborted_o=1; no wren_o.
//     A result injected 2 cycles later is ignored.
//  5. wb_en=0 instruction -> no wren_o; retired_o increments; ready_o=1 next cycle.
//  6. rst_i asserted during WAIT -> next edge: IDLE, ready_o=1, counters=0.
//     A following instruction completes normally.

Source files
------------

// File: rtl/acc_pkg.sv
// Shared types for the accelerator instruction sequencer: instruction format,
// FPU operation codes, register-file data/address types and sequencer states.
package acc_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned REG_ADDR_W = 5;

  typedef logic [DATA_W-1:0]     data_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef enum logic [2:0] {
    OP_FMADD  = 3'd0,
    OP_FMSUB  = 3'd1,
    OP_FNMADD = 3'd2,
    OP_FNMSUB = 3'd3,
    OP_PIVOT  = 3'd4,
    OP_FMUL   = 3'd5,
    OP_FADD   = 3'd6
  } acc_op_t;

  typedef struct packed {
    acc_op_t         op;
    reg_addr_t [2:0] rs;
    reg_addr_t       rd;
    logic            wb_en;
  } acc_instr_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    WRITE = 3'd4
  } seq_state_e;

  // Timer needs to hold TIMEOUT_CYCLES-1 plus one spare bit for saturation headroom.
  function automatic int unsigned timer_width(input int unsigned cycles);
    return $clog2(cycles) + 1;
  endfunction

endpackage

// File: rtl/acc_instr_seq_if.sv
// Bundle of all sequencer-facing buses: instruction input, register-file
// read/write ports, FPU issue/result and status counters.
interface acc_instr_seq_if
  import acc_pkg::*;
#(
  parameter int unsigned CNT_W = 32
);

  acc_instr_t       acc_instr_i;
  logic             acc_instr_valid_i;
  logic             ready_o;
  logic             busy_o;

  reg_addr_t [2:0]  raddr_o;
  logic             rready_o;
  data_t [2:0]      rdata_i;
  logic             rvalid_i;

  reg_addr_t        waddr_o;
  data_t            wdata_o;
  logic             wren_o;
  logic             wready_i;

  acc_op_t          fpu_op_o;
  data_t [2:0]      fpu_opnd_o;
  logic             fpu_valid_o;
  logic             fpu_ready_i;
  data_t            fpu_result_i;
  logic             fpu_result_valid_i;

  logic             err_o;
  logic [CNT_W-1:0] retired_o;
  logic [CNT_W-1:0] aborted_o;

  modport slave (
    input  acc_instr_i, acc_instr_valid_i,
    output ready_o, busy_o,
    output raddr_o, rready_o,
    input  rdata_i, rvalid_i,
    output waddr_o, wdata_o, wren_o,
    input  wready_i,
    output fpu_op_o, fpu_opnd_o, fpu_valid_o,
    input  fpu_ready_i, fpu_result_i, fpu_result_valid_i,
    output err_o, retired_o, aborted_o
  );

  modport master (
    output acc_instr_i, acc_instr_valid_i,
    input  ready_o, busy_o,
    input  raddr_o, rready_o,
    output rdata_i, rvalid_i,
    input  waddr_o, wdata_o, wren_o,
    output wready_i,
    input  fpu_op_o, fpu_opnd_o, fpu_valid_o,
    output fpu_ready_i, fpu_result_i, fpu_result_valid_i,
    input  err_o, retired_o, aborted_o
  );

endinterface

// File: rtl/acc_seq_timer.sv
// Clearable saturating up-counter with an equality compare against LIMIT;
// used to bound how long the sequencer waits for an FPU result.
module acc_seq_timer #(
  parameter int unsigned LIMIT = 63,
  parameter int unsigned W     = 7
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_reg <= '0;
    end else if (clr_i) begin
      count_reg <= '0;
    end else if (en_i && (count_reg != {W{1'b1}})) begin
      count_reg <= count_reg + W'(1);
    end
  end

  assign expired_o = (count_reg == W'(LIMIT));

endmodule

// File: rtl/acc_instr_seq.sv
// Single-issue accelerator instruction sequencer: read three operands, issue to
// the FPU, wait (bounded) for the result, optionally write it back.
module acc_instr_seq
  import acc_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 32
) (
  input logic            clk_i,
  input logic            rst_i,
  acc_instr_seq_if.slave bus
);

  localparam logic [2:0] S_IDLE  = IDLE;
  localparam logic [2:0] S_READ  = READ;
  localparam logic [2:0] S_ISSUE = ISSUE;
  localparam logic [2:0] S_WAIT  = WAIT;
  localparam logic [2:0] S_WRITE = WRITE;

  localparam int unsigned TMR_W = timer_width(TIMEOUT_CYCLES);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  logic [2:0]       state_reg;
  acc_instr_t       instr_reg;
  data_t [2:0]      opnd_reg;
  data_t            result_reg;
  logic [CNT_W-1:0] retired_reg;
  logic [CNT_W-1:0] aborted_reg;
  logic             err_reg;

  logic timer_clr;
  logic timer_en;
  logic timer_expired;

  assign timer_clr = (state_reg == S_ISSUE) && bus.fpu_ready_i;
  assign timer_en  = (state_reg == S_WAIT);

  acc_seq_timer #(
    .LIMIT (TIMEOUT_CYCLES - 1),
    .W     (TMR_W)
  ) u_timer (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (timer_clr),
    .en_i      (timer_en),
    .expired_o (timer_expired)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg   <= S_IDLE;
      instr_reg   <= '0;
      opnd_reg    <= '0;
      result_reg  <= '0;
      retired_reg <= '0;
      aborted_reg <= '0;
      err_reg     <= 1'b0;
    end else begin
      err_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (bus.acc_instr_valid_i) begin
            instr_reg <= bus.acc_instr_i;
            state_reg <= S_READ;
          end
        end
        S_READ: begin
          if (bus.rvalid_i) begin
            opnd_reg  <= bus.rdata_i;
            state_reg <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (bus.fpu_ready_i) begin
            state_reg <= S_WAIT;
          end
        end
        S_WAIT: begin
          // A result landing on the expiry cycle still completes the instruction.
          if (bus.fpu_result_valid_i) begin
            result_reg <= bus.fpu_result_i;
            if (instr_reg.wb_en) begin
              state_reg <= S_WRITE;
            end else begin
              retired_reg <= retired_reg + 1'b1;
              state_reg   <= S_IDLE;
            end
          end else if (timer_expired) begin
            err_reg     <= 1'b1;
            aborted_reg <= aborted_reg + 1'b1;
            state_reg   <= S_IDLE;
          end
        end
        S_WRITE: begin
          if (bus.wready_i) begin
            retired_reg <= retired_reg + 1'b1;
            state_reg   <= S_IDLE;
          end
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  // Every output comes from a register or a state decode, never from an input.
  for (genvar gi = 0; gi < 3; gi++) begin : g_operands
    assign bus.raddr_o[gi]    = instr_reg.rs[gi];
    assign bus.fpu_opnd_o[gi] = opnd_reg[gi];
  end

  assign bus.ready_o     = (state_reg == S_IDLE);
  assign bus.busy_o      = (state_reg != S_IDLE);
  assign bus.rready_o    = (state_reg == S_READ);
  assign bus.fpu_valid_o = (state_reg == S_ISSUE);
  assign bus.fpu_op_o    = instr_reg.op;
  assign bus.wren_o      = (state_reg == S_WRITE);
  assign bus.waddr_o     = instr_reg.rd;
  assign bus.wdata_o     = result_reg;
  assign bus.err_o       = err_reg;
  assign bus.retired_o   = retired_reg;
  assign bus.aborted_o   = aborted_reg;

endmodule
